// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the program ROM.
// Each instruction takes FETCH, DECODE, EXEC. addi writes the register file
// for one cycle. out holds a valid/ready transaction until it is accepted.
module instr_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter bit WRAP   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_inst,
  output logic [2:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_port,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [3:0]        OP_ADDI = 4'b0001;
  localparam logic [3:0]        OP_OUT  = 4'b1111;
  localparam logic [ADDR_W-1:0] PC_LAST = '1;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   pc_next;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   src;
  logic                ir_load;
  logic                src_load;
  logic                is_addi;
  logic                is_out;

  // IR[8] carries no meaning in the encoding.
  logic                unused_ir_bit;
  assign unused_ir_bit = ir[8];

  assign is_addi = (ir[15:12] == OP_ADDI);
  assign is_out  = (ir[15:12] == OP_OUT);

  // Datapath outputs are views of PC/IR/SRC, so reset clears them too.
  assign rom_addr = pc;
  assign rf_raddr = ir[11:9];
  assign rf_waddr = ir[11:9];
  assign rf_wdata = src + DATA_W'(ir[7:0]);
  assign out_port = ir[2:0];
  assign out_data = src;
  assign busy     = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign halted   = (state == S_HALT);

  // State, program counter and instruction/source latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      src   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (ir_load)  ir  <= rom_inst;
      if (src_load) src <= rf_rdata;
    end
  end

  // Next-state, PC advance and execute strobes.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_load    = 1'b0;
    src_load   = 1'b0;
    rf_we      = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        ir_load    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        src_load   = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        rf_we     = is_addi;
        out_valid = is_out;
        // Non-out instructions complete immediately; out waits for the handshake.
        if (!is_out || out_ready) begin
          if (!WRAP && (pc == PC_LAST)) begin
            state_next = S_HALT;
          end else begin
            pc_next    = pc + 1'b1;
            state_next = run ? S_FETCH : S_IDLE;
          end
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: ROM and register file modelled here,
// expected values written out by hand for each scenario.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: default parameters (WRAP=0)
  logic        rst, run, out_ready;
  logic [3:0]  rom_addr;
  logic [15:0] rom_inst;
  logic [2:0]  rf_raddr, rf_waddr, out_port;
  logic [7:0]  rf_rdata, rf_wdata, out_data;
  logic        rf_we, out_valid, busy, halted;

  // DUT 1: WRAP=1
  logic        rst1, run1;
  logic [3:0]  rom_addr1;
  logic [15:0] rom_inst1;
  logic [2:0]  rf_raddr1, rf_waddr1, out_port1;
  logic [7:0]  rf_rdata1, rf_wdata1, out_data1;
  logic        rf_we1, out_valid1, busy1, halted1;

  logic [15:0] rom  [16];
  logic [15:0] rom1 [16];
  logic [7:0]  regs [8];
  logic [7:0]  init_regs [8];
  logic        do_init;

  logic [2:0]  wr_addr_log [32];
  logic [7:0]  wr_data_log [32];
  logic [2:0]  out_port_log [32];
  logic [7:0]  out_data_log [32];
  int          wr_cnt, out_cnt, overlap_cnt;
  int          we1_cnt, ov1_cnt, halt1_cnt;

  int          checks = 0;
  int          errors = 0;

  assign rom_inst  = rom[rom_addr];
  assign rf_rdata  = regs[rf_raddr];
  assign rom_inst1 = rom1[rom_addr1];
  assign rf_rdata1 = 8'h00;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .rom_addr(rom_addr), .rom_inst(rom_inst),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_port(out_port), .out_data(out_data),
    .busy(busy), .halted(halted)
  );

  instr_sequencer #(.ADDR_W(4), .DATA_W(8), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst1), .run(run1),
    .rom_addr(rom_addr1), .rom_inst(rom_inst1),
    .rf_raddr(rf_raddr1), .rf_rdata(rf_rdata1),
    .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1),
    .out_valid(out_valid1), .out_ready(1'b1),
    .out_port(out_port1), .out_data(out_data1),
    .busy(busy1), .halted(halted1)
  );

  // Register-file sink and transaction logs for DUT 0.
  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 8; i++) regs[i] <= init_regs[i];
      wr_cnt      <= 0;
      out_cnt     <= 0;
      overlap_cnt <= 0;
    end else begin
      if (rf_we) begin
        regs[rf_waddr] <= rf_wdata;
        if (wr_cnt < 32) begin
          wr_addr_log[wr_cnt] <= rf_waddr;
          wr_data_log[wr_cnt] <= rf_wdata;
        end
        wr_cnt <= wr_cnt + 1;
      end
      if (out_valid && out_ready) begin
        if (out_cnt < 32) begin
          out_port_log[out_cnt] <= out_port;
          out_data_log[out_cnt] <= out_data;
        end
        out_cnt <= out_cnt + 1;
      end
      if (rf_we && out_valid) overlap_cnt <= overlap_cnt + 1;
    end
  end

  // Activity counters for the wrapping instance.
  always @(posedge clk) begin
    if (rst1) begin
      we1_cnt   <= 0;
      ov1_cnt   <= 0;
      halt1_cnt <= 0;
    end else begin
      if (rf_we1)     we1_cnt   <= we1_cnt + 1;
      if (out_valid1) ov1_cnt   <= ov1_cnt + 1;
      if (halted1)    halt1_cnt <= halt1_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
  endtask

  task automatic clear_init();
    for (int i = 0; i < 8; i++) init_regs[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    do_init = 1'b1;
    step(2);
    rst     = 1'b0;
    do_init = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cycles;
    rst = 1'b1; run = 1'b0; out_ready = 1'b1; do_init = 1'b1;
    rst1 = 1'b1; run1 = 1'b0;
    clear_rom();
    clear_init();
    for (int i = 0; i < 16; i++) rom1[i] = 16'h0000;

    // ---- Test 1: stock program, reset state, full run to HALT
    for (int i = 0; i < 8; i++) begin
      rom[i]     = {4'b0001, 3'(i), 1'b0, 8'(i)};         // addi ri, i
      rom[i + 8] = {4'b1111, 3'(i), 1'b0, 5'b0, 3'(i)};   // out ri -> port i
    end
    run = 1'b1;
    step(2);
    check("rst_busy",      busy,      0);
    check("rst_halted",    halted,    0);
    check("rst_rom_addr",  rom_addr,  0);
    check("rst_rf_we",     rf_we,     0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rf_raddr",  rf_raddr,  0);
    check("rst_rf_waddr",  rf_waddr,  0);
    check("rst_rf_wdata",  rf_wdata,  0);
    check("rst_out_port",  out_port,  0);
    check("rst_out_data",  out_data,  0);
    rst = 1'b0; do_init = 1'b0;
    cycles = 0;
    while (!halted && cycles < 200) begin
      step(1);
      cycles++;
    end
    // one IDLE->FETCH edge, then 16 instructions x 3 cycles
    check("t1_halt_cycles", cycles, 49);
    check("t1_wr_cnt", wr_cnt, 8);
    check("t1_out_cnt", out_cnt, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_wr_addr%0d", i),  wr_addr_log[i],  i);
      check($sformatf("t1_wr_data%0d", i),  wr_data_log[i],  i);
      check($sformatf("t1_out_port%0d", i), out_port_log[i], i);
      check($sformatf("t1_out_data%0d", i), out_data_log[i], i);
    end
    check("t1_overlap", overlap_cnt, 0);
    step(5);
    check("t1_halt_sticky", halted, 1);
    check("t1_halt_busy",   busy,   0);

    // ---- Test 2: addi wraps modulo 256, single-cycle rf_we
    run = 1'b0;
    clear_rom();
    rom[0] = 16'h16FF;            // addi r3, 0xFF
    clear_init();
    init_regs[3] = 8'h02;
    do_reset();
    run = 1'b1;
    step(3);
    check("t2_rf_we",     rf_we,     1);
    check("t2_rf_waddr",  rf_waddr,  3);
    check("t2_rf_wdata",  rf_wdata,  8'h01);
    check("t2_out_valid", out_valid, 0);
    step(1);
    check("t2_rf_we_drop", rf_we,    0);
    check("t2_pc_next",    rom_addr, 1);
    check("t2_r3",         regs[3],  8'h01);
    run = 1'b0;

    // ---- Test 3: out stalled for 5 cycles
    clear_rom();
    rom[0] = 16'hFA06;            // out r5 -> port 6
    clear_init();
    init_regs[5] = 8'h5A;
    out_ready = 1'b0;
    do_reset();
    run = 1'b1;
    step(3);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_valid_c%0d", i), out_valid, 1);
      check($sformatf("t3_data_c%0d", i),  out_data,  8'h5A);
      check($sformatf("t3_port_c%0d", i),  out_port,  6);
      check($sformatf("t3_pc_c%0d", i),    rom_addr,  0);
      check($sformatf("t3_we_c%0d", i),    rf_we,     0);
      if (i < 5) step(1);
    end
    out_ready = 1'b1;
    step(1);
    check("t3_valid_drop", out_valid, 0);
    check("t3_pc_adv",     rom_addr,  1);
    check("t3_out_cnt",    out_cnt,   1);
    check("t3_log_data",   out_data_log[0], 8'h5A);
    check("t3_log_port",   out_port_log[0], 6);
    run = 1'b0;

    // ---- Test 4: run dropped during DECODE
    clear_rom();
    rom[0] = 16'h1205;            // addi r1, 5
    rom[1] = 16'h1407;            // addi r2, 7
    clear_init();
    init_regs[1] = 8'h10;
    init_regs[2] = 8'h20;
    do_reset();
    run = 1'b1;
    step(2);                      // DECODE
    run = 1'b0;
    step(1);                      // EXEC
    check("t4_rf_we",    rf_we,    1);
    check("t4_rf_wdata", rf_wdata, 8'h15);
    step(1);
    check("t4_idle_busy", busy,     0);
    check("t4_idle_pc",   rom_addr, 1);
    step(3);
    check("t4_idle_hold", busy,     0);
    check("t4_pc_hold",   rom_addr, 1);
    run = 1'b1;
    step(1);
    check("t4_resume_busy", busy,     1);
    check("t4_resume_pc",   rom_addr, 1);
    step(2);
    check("t4_r2_we",    rf_we,    1);
    check("t4_r2_waddr", rf_waddr, 2);
    check("t4_r2_wdata", rf_wdata, 8'h27);
    run = 1'b0;

    // ---- Test 5: WRAP=1 instance, NOP-only program
    rom1[3] = 16'h2345;           // unassigned opcode, also a NOP
    rst1 = 1'b1;
    run1 = 1'b1;
    step(2);
    rst1 = 1'b0;
    step(1 + 3 * 15);             // FETCH of slot 15
    check("t5_pc15",     rom_addr1, 15);
    step(3);                      // FETCH of slot 0 after wrap
    check("t5_pc_wrap",  rom_addr1, 0);
    check("t5_busy",     busy1,     1);
    check("t5_halted",   halted1,   0);
    step(9);
    check("t5_pc_after", rom_addr1, 3);
    check("t5_halt_cnt", halt1_cnt, 0);
    check("t5_no_we",    we1_cnt,   0);
    check("t5_no_out",   ov1_cnt,   0);
    run1 = 1'b0;
    rst1 = 1'b1;

    // ---- Test 6: reset during a stalled out
    clear_rom();
    rom[0] = 16'h1001;            // addi r0, 1
    rom[1] = 16'hFA06;            // out r5 -> port 6
    clear_init();
    init_regs[5] = 8'h33;
    out_ready = 1'b0;
    do_reset();
    run = 1'b1;
    step(6);
    check("t6_stall_valid", out_valid, 1);
    check("t6_stall_pc",    rom_addr,  1);
    check("t6_stall_data",  out_data,  8'h33);
    rst = 1'b1;
    step(1);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_pc",    rom_addr,  0);
    check("t6_rst_busy",  busy,      0);
    check("t6_rst_port",  out_port,  0);
    check("t6_rst_data",  out_data,  0);
    rst = 1'b0;
    run = 1'b0;
    step(2);
    check("t6_idle_busy", busy,     0);
    check("t6_idle_pc",   rom_addr, 0);
    check("t6_out_cnt",   out_cnt,  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
